// File: rtl/hit_uart_reporter.sv
// Reports each hit count as a 4-byte ASCII message ("TO\r\n") over an 8N1 UART line.
// Latency: a valid count accepted in idle drives the start bit in the next cycle.
// Backpressure: none. A one-deep pending slot holds a count that arrives while busy; a newer count overwrites it and pulses o_drop.
module hit_uart_reporter #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hit_valid,
    input  logic [5:0] i_hit_count,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_drop
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [5:0]    cur_count;
    logic [5:0]    pend_count;
    logic          pend_vld;

    logic          bit_end;
    logic          busy_hit;
    logic          next_vld;
    logic [5:0]    next_count;
    logic [2:0]    tens;
    logic [5:0]    tens_base;
    logic [5:0]    ones;
    logic [7:0]    cur_byte;

    assign bit_end  = (clk_cnt == LAST_CLK);
    assign busy_hit = i_hit_valid && (state != IDLE);

    // A count arriving in the last stop cycle is chained straight into the next message.
    assign next_vld   = pend_vld || busy_hit;
    assign next_count = busy_hit ? i_hit_count : pend_count;

    always_comb begin
        tens      = 3'd0;
        tens_base = 6'd0;
        if (cur_count >= 6'd60) begin
            tens = 3'd6; tens_base = 6'd60;
        end else if (cur_count >= 6'd50) begin
            tens = 3'd5; tens_base = 6'd50;
        end else if (cur_count >= 6'd40) begin
            tens = 3'd4; tens_base = 6'd40;
        end else if (cur_count >= 6'd30) begin
            tens = 3'd3; tens_base = 6'd30;
        end else if (cur_count >= 6'd20) begin
            tens = 3'd2; tens_base = 6'd20;
        end else if (cur_count >= 6'd10) begin
            tens = 3'd1; tens_base = 6'd10;
        end
        ones = cur_count - tens_base;
    end

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            2'd0:    cur_byte = 8'h30 + {5'b00000, tens};
            2'd1:    cur_byte = 8'h30 + {2'b00, ones};
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Line is decoded from registered state so reset forces it idle without a clock.
    always_comb begin
        o_tx = 1'b1;
        case (state)
            START:   o_tx = 1'b0;
            DATA:    o_tx = cur_byte[bit_idx];
            default: o_tx = 1'b1;
        endcase
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 2'd0;
            cur_count  <= 6'd0;
            pend_count <= 6'd0;
            pend_vld   <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_drop <= busy_hit && pend_vld;
            if (busy_hit) begin
                pend_vld   <= 1'b1;
                pend_count <= i_hit_count;
            end
            case (state)
                IDLE: begin
                    if (i_hit_valid) begin
                        state     <= START;
                        cur_count <= i_hit_count;
                        byte_idx  <= 2'd0;
                        clk_cnt   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= START;
                        end else if (next_vld) begin
                            cur_count <= next_count;
                            byte_idx  <= 2'd0;
                            pend_vld  <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_uart_reporter.sv
// Directed bench for hit_uart_reporter: message waveforms, pending/drop, boundary chaining, reset abort, full sweep.
module tb_hit_uart_reporter;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hit_valid = 1'b0;
    logic [5:0] hit_count = 6'd0;
    logic       tx;
    logic       busy;
    logic       drop;

    int checks = 0;
    int errors = 0;

    hit_uart_reporter #(.CLKS_PER_BIT(C)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_hit_valid (hit_valid),
        .i_hit_count (hit_count),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the negedge of the first message cycle.
    task automatic pulse(input logic [5:0] c);
        @(negedge clk);
        hit_valid = 1'b1;
        hit_count = c;
        @(negedge clk);
        hit_valid = 1'b0;
    endtask

    // Called at the negedge of the first start-bit cycle; walks the whole 40-bit message.
    task automatic expect_msg(input string tag, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] exp_b [4];
        logic [7:0] got   [4];
        int wave_err, frame_err, busy_cyc, k, j, p;
        logic e;
        exp_b[0] = d0;
        exp_b[1] = d1;
        exp_b[2] = 8'h0D;
        exp_b[3] = 8'h0A;
        for (int n = 0; n < 4; n++) got[n] = 8'h00;
        wave_err  = 0;
        frame_err = 0;
        busy_cyc  = 0;
        for (int i = 0; i < 40 * C; i++) begin
            k = i / (10 * C);
            j = (i / C) % 10;
            p = i % C;
            if (j == 0)      e = 1'b0;
            else if (j == 9) e = 1'b1;
            else             e = exp_b[k][j-1];
            if (tx !== e) wave_err++;
            if (busy === 1'b1) busy_cyc++;
            if (p == C / 2) begin
                if (j == 0) begin
                    if (tx !== 1'b0) frame_err++;
                end else if (j == 9) begin
                    if (tx !== 1'b1) frame_err++;
                end else begin
                    got[k][j-1] = tx;
                end
            end
            @(negedge clk);
        end
        for (int n = 0; n < 4; n++) check($sformatf("%s byte%0d", tag, n), got[n], exp_b[n]);
        check($sformatf("%s framing", tag), frame_err, 0);
        check($sformatf("%s waveform", tag), wave_err, 0);
        check($sformatf("%s busy_cycles", tag), busy_cyc, 40 * C);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drop_n;
        int drop_cyc;
        int idle_err;

        // Reset with a valid held high: outputs idle, valid ignored.
        hit_valid = 1'b1;
        hit_count = 6'd33;
        #1;
        check("rst tx", tx, 1);
        check("rst busy", busy, 0);
        check("rst drop", drop, 0);
        repeat (3) @(negedge clk);
        check("rst hold busy", busy, 0);
        rst       = 1'b1;
        hit_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst tx", tx, 1);
        check("post_rst busy", busy, 0);

        // Basic message and range endpoints.
        pulse(6'd42);
        expect_msg("m42", 8'h34, 8'h32);
        check("m42 busy_after", busy, 0);
        check("m42 tx_after", tx, 1);
        pulse(6'd0);
        expect_msg("m00", 8'h30, 8'h30);
        pulse(6'd63);
        expect_msg("m63", 8'h36, 8'h33);
        pulse(6'd9);
        expect_msg("m09", 8'h30, 8'h39);

        // Pending overwrite: 10 at cycle 0, 20 at 50, 30 at 100.
        drop_n   = 0;
        drop_cyc = -1;
        @(negedge clk);
        fork
            begin
                hit_valid = 1'b1; hit_count = 6'd10;
                @(negedge clk);
                hit_valid = 1'b0;
                repeat (49) @(negedge clk);
                hit_valid = 1'b1; hit_count = 6'd20;
                @(negedge clk);
                hit_valid = 1'b0;
                repeat (49) @(negedge clk);
                hit_valid = 1'b1; hit_count = 6'd30;
                @(negedge clk);
                hit_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 850; i++) begin
                    if (drop === 1'b1) begin
                        drop_n++;
                        drop_cyc = i;
                    end
                    @(negedge clk);
                end
            end
            begin
                @(negedge clk);
                expect_msg("drop_first", 8'h31, 8'h30);
                expect_msg("drop_second", 8'h33, 8'h30);
                check("drop busy_after", busy, 0);
            end
        join
        check("drop pulses", drop_n, 1);
        check("drop cycle", drop_cyc, 101);

        // Valid in the final stop cycle chains with no gap; input changes after capture are ignored.
        @(negedge clk);
        fork
            begin
                hit_valid = 1'b1; hit_count = 6'd12;
                @(negedge clk);
                hit_valid = 1'b0; hit_count = 6'd55;
                repeat (399) @(negedge clk);
                hit_valid = 1'b1; hit_count = 6'd7;
                @(negedge clk);
                hit_valid = 1'b0; hit_count = 6'd0;
            end
            begin
                @(negedge clk);
                expect_msg("chain_first", 8'h31, 8'h32);
                expect_msg("chain_second", 8'h30, 8'h37);
                check("chain busy_after", busy, 0);
            end
        join

        // Reset during data bits of byte 1 aborts asynchronously.
        pulse(6'd42);
        repeat (150) @(negedge clk);
        #2;
        rst       = 1'b0;
        hit_valid = 1'b1;
        hit_count = 6'd21;
        #1;
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        check("abort drop", drop, 0);
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        hit_valid = 1'b0;
        idle_err  = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) idle_err++;
            @(negedge clk);
        end
        check("abort no_remnant", idle_err, 0);
        pulse(6'd5);
        expect_msg("after_abort", 8'h30, 8'h35);

        // Every count, serially.
        for (int c = 0; c < 64; c++) begin
            pulse(6'(c));
            expect_msg($sformatf("sweep%0d", c), 8'(8'h30 + c / 10), 8'(8'h30 + c % 10));
        end
        check("sweep busy_after", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
